// File: rtl/rate_converter_5b_s_axi_regs.sv
// AXI4-Lite slave exposing four 32-bit control registers to the rate-converter datapath.
// Optional macro RATE_CONV_WSTRB_EN enables per-byte write strobes; otherwise every write replaces the full word.
module rate_converter_5b_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_t;

    w_state_t        w_state;
    logic            aw_ready;
    logic            w_ready;
    logic            b_valid;
    logic [1:0]      addr_q;
    logic [DW-1:0]   data_q;
    logic [SW-1:0]   strb_q;
    logic [DW-1:0]   regs [4];

    logic            aw_hs;
    logic            w_hs;
    logic            commit;
    logic [1:0]      commit_idx;
    logic [DW-1:0]   commit_data;
    logic [SW-1:0]   commit_strb;

    logic            ar_en;
    logic            ar_ready;
    logic            ar_hs;
    logic            r_valid;
    logic [DW-1:0]   r_data;

    // Whichever beat arrives last completes the write; the earlier one comes from the capture registers.
    always_comb begin
        aw_hs       = S_AXI_AWVALID & aw_ready;
        w_hs        = S_AXI_WVALID & w_ready;
        commit      = 1'b0;
        commit_idx  = S_AXI_AWADDR[3:2];
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
        case (w_state)
            W_IDLE:      commit = aw_hs & w_hs;
            W_HAVE_ADDR: begin
                commit     = w_hs;
                commit_idx = addr_q;
            end
            W_HAVE_DATA: begin
                commit      = aw_hs;
                commit_data = data_q;
                commit_strb = strb_q;
            end
            default:     commit = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (commit) begin
`ifdef RATE_CONV_WSTRB_EN
                for (int b = 0; b < SW; b++)
                    if (commit_strb[b]) regs[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
`else
                regs[commit_idx] <= commit_data;
`endif
            end
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        w_state  <= W_RESP;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b0;
                        b_valid  <= 1'b1;
                    end else if (aw_hs) begin
                        w_state  <= W_HAVE_ADDR;
                        addr_q   <= S_AXI_AWADDR[3:2];
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                    end else if (w_hs) begin
                        w_state  <= W_HAVE_DATA;
                        data_q   <= S_AXI_WDATA;
                        strb_q   <= S_AXI_WSTRB;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b0;
                    end else begin
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                    end
                end
                W_HAVE_ADDR: begin
                    if (commit) begin
                        w_state <= W_RESP;
                        w_ready <= 1'b0;
                        b_valid <= 1'b1;
                    end
                end
                W_HAVE_DATA: begin
                    if (commit) begin
                        w_state  <= W_RESP;
                        aw_ready <= 1'b0;
                        b_valid  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        w_state  <= W_IDLE;
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ar_en keeps ARREADY low throughout reset even though RVALID is already clear.
    assign ar_ready = ar_en & ~r_valid;
    assign ar_hs    = S_AXI_ARVALID & ar_ready;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ar_en   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            ar_en <= 1'b1;
            if (ar_hs) begin
                r_valid <= 1'b1;
                r_data  <= regs[S_AXI_ARADDR[3:2]];
            end else if (r_valid && S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = 2'b00;

    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];

    // Protection bits and the byte offset within a word carry no meaning for this register file.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, commit_strb};

endmodule

// File: tb/tb_rate_converter_5b_s_axi_regs.sv
// Randomized self-checking bench for rate_converter_5b_s_axi_regs against a word-level register model.
// Honours RATE_CONV_WSTRB_EN the same way as the design build.
module tb_rate_converter_5b_s_axi_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;

    int compare_count  = 0;
    int mismatch_count = 0;
    logic [31:0] model_regs [4];

    rate_converter_5b_s_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] dut_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    return slv_reg0;
            2'd1:    return slv_reg1;
            2'd2:    return slv_reg2;
            default: return slv_reg3;
        endcase
    endfunction

    // Word-level effect of one committed write.
    function automatic logic [31:0] model_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                                input logic [3:0] strb);
        logic [31:0] result;
`ifdef RATE_CONV_WSTRB_EN
        result = old_val;
        for (int b = 0; b < 4; b++)
            if (strb[b]) result[b*8 +: 8] = new_val[b*8 +: 8];
`else
        result = new_val;
        if (strb === 4'hx) result = old_val;
`endif
        return result;
    endfunction

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s_reg%0d", tag, i), dut_reg(2'(i)), model_regs[i]);
    endtask

    task automatic apply_reset;
        ARESETN       = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b0;
        repeat (2) tick;
        for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
        checkOutput("rst_ready", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
        checkOutput("rst_valid", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
        checkOutput("rst_rdata", S_AXI_RDATA, 32'h0);
        checkOutput("rst_resp", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
        check_all_regs("rst");
        ARESETN = 1'b1;
        tick;
        checkOutput("post_rst_ready", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int b_delay);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_fire;
        bit w_fire;
        int cyc = 0;
        int commit_cyc = -1;
        int exp_commit = (aw_delay > w_delay) ? aw_delay : w_delay;
        S_AXI_AWADDR = addr;
        S_AXI_AWPROT = 3'($urandom);
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_delay);
            S_AXI_WVALID  = !w_done && (cyc >= w_delay);
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            tick;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            if (aw_done && w_done) commit_cyc = cyc;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        checkOutput("w_commit_cycle", commit_cyc, exp_commit);
        if (commit_cyc >= 0)
            model_regs[addr[3:2]] = model_merge(model_regs[addr[3:2]], data, strb);
        checkOutput("w_bvalid", {31'd0, S_AXI_BVALID}, 32'h1);
        checkOutput("w_bresp", {30'd0, S_AXI_BRESP}, 32'h0);
        checkOutput("w_reg", dut_reg(addr[3:2]), model_regs[addr[3:2]]);
        S_AXI_BREADY = 1'b0;
        for (int i = 0; i < b_delay; i++) begin
            tick;
            checkOutput("w_bhold_bvalid", {31'd0, S_AXI_BVALID}, 32'h1);
            checkOutput("w_bhold_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
        end
        S_AXI_BREADY = 1'b1;
        tick;
        S_AXI_BREADY = 1'b0;
        checkOutput("w_bdone_bvalid", {31'd0, S_AXI_BVALID}, 32'h0);
        checkOutput("w_bdone_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_delay);
        int waited = 0;
        logic [31:0] expected;
        while (!S_AXI_ARREADY && waited < 20) begin
            tick;
            waited++;
        end
        checkOutput("r_arready", {31'd0, S_AXI_ARREADY}, 32'h1);
        S_AXI_ARADDR  = addr;
        S_AXI_ARPROT  = 3'($urandom);
        S_AXI_ARVALID = 1'b1;
        expected      = model_regs[addr[3:2]];
        tick;
        S_AXI_ARVALID = 1'b0;
        checkOutput("r_rvalid", {31'd0, S_AXI_RVALID}, 32'h1);
        checkOutput("r_rdata", S_AXI_RDATA, expected);
        checkOutput("r_rresp", {30'd0, S_AXI_RRESP}, 32'h0);
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < r_delay; i++) begin
            tick;
            checkOutput("r_hold_rvalid", {31'd0, S_AXI_RVALID}, 32'h1);
            checkOutput("r_hold_rdata", S_AXI_RDATA, expected);
            checkOutput("r_hold_arready", {31'd0, S_AXI_ARREADY}, 32'h0);
        end
        S_AXI_RREADY = 1'b1;
        tick;
        S_AXI_RREADY = 1'b0;
        checkOutput("r_done_rvalid", {31'd0, S_AXI_RVALID}, 32'h0);
        checkOutput("r_done_arready", {31'd0, S_AXI_ARREADY}, 32'h1);
    endtask

    // Write and read the same word in one cycle: the read must see the old contents.
    task automatic same_cycle_rw(input logic [1:0] idx, input logic [31:0] data);
        logic [31:0] old_val = model_regs[idx];
        S_AXI_AWADDR  = {idx, 2'b00};
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = {idx, 2'b00};
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        tick;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        model_regs[idx] = model_merge(old_val, data, 4'hF);
        checkOutput("rw_rdata_old", S_AXI_RDATA, old_val);
        checkOutput("rw_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'h3);
        checkOutput("rw_reg_new", dut_reg(idx), model_regs[idx]);
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        tick;
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        checkOutput("rw_valids_done", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
    endtask

    task automatic applyStimulus(input int n_ops);
        for (int k = 0; k < n_ops; k++) begin
            logic [3:0] addr = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2));
            else
                axi_read(addr, $urandom_range(0, 2));
        end
        check_all_regs("rand");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA  = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        ARESETN      = 1'b0;
        $display("[TB] starting");
        apply_reset;

        for (int i = 0; i < 4; i++)
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            axi_read(4'(i * 4), 0);
        check_all_regs("basic");

        // W first, AW three cycles later, then a slow B and a slow R.
        axi_write(4'h8, 32'hCAFE_0028, 4'hF, 3, 0, 5);
        axi_write(4'h4, 32'h0BAD_F00D, 4'hF, 0, 2, 0);
        axi_read(4'h4, 4);
        axi_read(4'h8, 0);

        axi_write(4'h4, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'h1122_3344, 4'b0101, 0, 0, 0);
`ifdef RATE_CONV_WSTRB_EN
        checkOutput("strb_reg1", slv_reg1, 32'hAA22_CC44);
`else
        checkOutput("strb_reg1", slv_reg1, 32'h1122_3344);
`endif
        axi_write(4'h4, 32'hFFFF_FFFF, 4'h0, 1, 0, 1);

        same_cycle_rw(2'd3, 32'h5A5A_A5A5);

        // Abort a half-captured write and an outstanding read with reset.
        S_AXI_AWADDR  = 4'h4;
        S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR  = 4'hC;
        S_AXI_ARVALID = 1'b1;
        tick;
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARVALID = 1'b0;
        apply_reset;
        checkOutput("abort_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
        check_all_regs("abort");
        axi_write(4'hC, 32'h600D_0001, 4'hF, 2, 0, 0);
        axi_read(4'hC, 1);

        applyStimulus(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
